// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU op codes, reset words and
// the ID/EX control bundle.
package mips_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned ALU_OP_W  = 3;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_OP_FUNCT = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND   = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR    = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SLT   = 3'b101;

  // Control bits carried from ID to EX; an all-zero value is a bubble.
  typedef struct packed {
    logic                reg_dst;
    logic                alu_src;
    logic                mem_to_reg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with write-through
// bypass, one synchronous write port, $0 hardwired to zero.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset (clears all)
//   i_we/i_waddr/i_wdata write port (writes to $0 are dropped)
//   i_raddr1/o_rdata1    read port 1
//   i_raddr2/o_rdata2    read port 2
module register_file
  import mips_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [XLEN-1:0]      i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr1,
  input  logic [REG_IDX_W-1:0] i_raddr2,
  output logic [XLEN-1:0]      o_rdata1,
  output logic [XLEN-1:0]      o_rdata2
);

  logic [XLEN-1:0] r_regs [REG_COUNT];
  logic            w_wr_valid;

  assign w_wr_valid = i_we && (i_waddr != REG_IDX_W'(0));

  // Storage; entry 0 is never written so it stays at its reset value of 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_valid) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Same-cycle writeback is forwarded so decode never sees a stale value.
  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    if (i_raddr1 != REG_IDX_W'(0)) begin
      o_rdata1 = (w_wr_valid && i_waddr == i_raddr1) ? i_wdata : r_regs[i_raddr1];
    end
    if (i_raddr2 != REG_IDX_W'(0)) begin
      o_rdata2 = (w_wr_valid && i_waddr == i_raddr2) ? i_wdata : r_regs[i_raddr2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: IF/ID register, register file, control
// decode, immediate extension, branch target, load-use hazard detection and
// the registered ID/EX bundle.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_instruction, in_pc_plus_four  fetched instruction and PC+4 from IF
//   in_flush                         taken branch: squash IF/ID and ID/EX control
//   in_wb_*                          writeback port into the register file
//   out_stall                        combinational load-use stall to IF
//   out_*                            registered ID/EX bundle to EX
module id_stage
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      in_instruction,
  input  logic [XLEN-1:0]      in_pc_plus_four,
  input  logic                 in_flush,
  input  logic                 in_wb_reg_write,
  input  logic [REG_IDX_W-1:0] in_wb_write_reg,
  input  logic [XLEN-1:0]      in_wb_write_data,
  output logic                 out_stall,
  output logic [XLEN-1:0]      out_pc_plus_four,
  output logic [XLEN-1:0]      out_branch_address,
  output logic [XLEN-1:0]      out_read_data_1,
  output logic [XLEN-1:0]      out_read_data_2,
  output logic [XLEN-1:0]      out_imm_ext,
  output logic [REG_IDX_W-1:0] out_rs,
  output logic [REG_IDX_W-1:0] out_rt,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic [5:0]           out_funct,
  output logic [ALU_OP_W-1:0]  out_alu_op,
  output logic                 out_reg_dst,
  output logic                 out_alu_src,
  output logic                 out_mem_to_reg,
  output logic                 out_reg_write,
  output logic                 out_mem_read,
  output logic                 out_mem_write,
  output logic                 out_branch
);

  logic [XLEN-1:0]      r_ifid_instr;
  logic [XLEN-1:0]      r_ifid_pc4;

  logic [OPCODE_W-1:0]  w_opcode;
  logic [REG_IDX_W-1:0] w_rs;
  logic [REG_IDX_W-1:0] w_rt;
  logic [REG_IDX_W-1:0] w_rd;
  logic [XLEN-1:0]      w_imm_ext;
  logic [XLEN-1:0]      w_branch_addr;
  logic [XLEN-1:0]      w_rdata1;
  logic [XLEN-1:0]      w_rdata2;
  ctrl_t                w_ctrl;
  logic                 w_uses_rt;
  logic                 w_stall;

  ctrl_t                r_idex_ctrl;
  logic [XLEN-1:0]      r_idex_pc4;
  logic [XLEN-1:0]      r_idex_baddr;
  logic [XLEN-1:0]      r_idex_rd1;
  logic [XLEN-1:0]      r_idex_rd2;
  logic [XLEN-1:0]      r_idex_imm;
  logic [REG_IDX_W-1:0] r_idex_rs;
  logic [REG_IDX_W-1:0] r_idex_rt;
  logic [REG_IDX_W-1:0] r_idex_rd;
  logic [5:0]           r_idex_funct;

  // IF/ID register: flush beats stall beats load.
  always_ff @(posedge clk) begin
    if (rst || in_flush) begin
      r_ifid_instr <= NOP_WORD;
      r_ifid_pc4   <= '0;
    end else if (!w_stall) begin
      r_ifid_instr <= in_instruction;
      r_ifid_pc4   <= in_pc_plus_four;
    end
  end

  assign w_opcode      = r_ifid_instr[31:26];
  assign w_rs          = r_ifid_instr[25:21];
  assign w_rt          = r_ifid_instr[20:16];
  assign w_rd          = r_ifid_instr[15:11];
  assign w_imm_ext     = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
  assign w_branch_addr = r_ifid_pc4 + {w_imm_ext[29:0], 2'b00};

  // Control decode; don't-care bits of sw/beq are driven 0.
  always_comb begin
    w_ctrl    = '0;
    w_uses_rt = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_ctrl.reg_dst   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_OP_FUNCT;
        w_uses_rt        = 1'b1;
      end
      OP_ADDI: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_OP_ADD;
      end
      OP_ANDI: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_OP_AND;
      end
      OP_ORI: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_OP_OR;
      end
      OP_SLTI: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_op    = ALU_OP_SLT;
      end
      OP_LW: begin
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.alu_op     = ALU_OP_ADD;
      end
      OP_SW: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_op    = ALU_OP_ADD;
        w_uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = ALU_OP_SUB;
        w_uses_rt     = 1'b1;
      end
      default: begin
        w_ctrl    = '0;
        w_uses_rt = 1'b0;
      end
    endcase
  end

  register_file u_regfile (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_we     (in_wb_reg_write),
    .i_waddr  (in_wb_write_reg),
    .i_wdata  (in_wb_write_data),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // Load in EX whose destination feeds this decode: hold one cycle.
  assign w_stall = r_idex_ctrl.mem_read && (r_idex_rt != REG_IDX_W'(0)) &&
                   ((r_idex_rt == w_rs) || (w_uses_rt && (r_idex_rt == w_rt)));
  assign out_stall = w_stall;

  // ID/EX register; flush or stall injects a control bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idex_ctrl  <= '0;
      r_idex_pc4   <= '0;
      r_idex_baddr <= '0;
      r_idex_rd1   <= '0;
      r_idex_rd2   <= '0;
      r_idex_imm   <= '0;
      r_idex_rs    <= '0;
      r_idex_rt    <= '0;
      r_idex_rd    <= '0;
      r_idex_funct <= '0;
    end else begin
      r_idex_ctrl  <= (in_flush || w_stall) ? ctrl_t'('0) : w_ctrl;
      r_idex_pc4   <= r_ifid_pc4;
      r_idex_baddr <= w_branch_addr;
      r_idex_rd1   <= w_rdata1;
      r_idex_rd2   <= w_rdata2;
      r_idex_imm   <= w_imm_ext;
      r_idex_rs    <= w_rs;
      r_idex_rt    <= w_rt;
      r_idex_rd    <= w_rd;
      r_idex_funct <= r_ifid_instr[5:0];
    end
  end

  assign out_pc_plus_four   = r_idex_pc4;
  assign out_branch_address = r_idex_baddr;
  assign out_read_data_1    = r_idex_rd1;
  assign out_read_data_2    = r_idex_rd2;
  assign out_imm_ext        = r_idex_imm;
  assign out_rs             = r_idex_rs;
  assign out_rt             = r_idex_rt;
  assign out_rd             = r_idex_rd;
  assign out_funct          = r_idex_funct;
  assign out_alu_op         = r_idex_ctrl.alu_op;
  assign out_reg_dst        = r_idex_ctrl.reg_dst;
  assign out_alu_src        = r_idex_ctrl.alu_src;
  assign out_mem_to_reg     = r_idex_ctrl.mem_to_reg;
  assign out_reg_write      = r_idex_ctrl.reg_write;
  assign out_mem_read       = r_idex_ctrl.mem_read;
  assign out_mem_write      = r_idex_ctrl.mem_write;
  assign out_branch         = r_idex_ctrl.branch;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a per-cycle vector table followed by
// hand-written sequences for register persistence and mid-stall reset.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] in_instruction;
  logic [31:0] in_pc_plus_four;
  logic        in_flush;
  logic        in_wb_reg_write;
  logic [4:0]  in_wb_write_reg;
  logic [31:0] in_wb_write_data;
  logic        out_stall;
  logic [31:0] out_pc_plus_four;
  logic [31:0] out_branch_address;
  logic [31:0] out_read_data_1;
  logic [31:0] out_read_data_2;
  logic [31:0] out_imm_ext;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [5:0]  out_funct;
  logic [2:0]  out_alu_op;
  logic        out_reg_dst;
  logic        out_alu_src;
  logic        out_mem_to_reg;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_branch;

  id_stage dut (
    .clk                (clk),
    .rst                (rst),
    .in_instruction     (in_instruction),
    .in_pc_plus_four    (in_pc_plus_four),
    .in_flush           (in_flush),
    .in_wb_reg_write    (in_wb_reg_write),
    .in_wb_write_reg    (in_wb_write_reg),
    .in_wb_write_data   (in_wb_write_data),
    .out_stall          (out_stall),
    .out_pc_plus_four   (out_pc_plus_four),
    .out_branch_address (out_branch_address),
    .out_read_data_1    (out_read_data_1),
    .out_read_data_2    (out_read_data_2),
    .out_imm_ext        (out_imm_ext),
    .out_rs             (out_rs),
    .out_rt             (out_rt),
    .out_rd             (out_rd),
    .out_funct          (out_funct),
    .out_alu_op         (out_alu_op),
    .out_reg_dst        (out_reg_dst),
    .out_alu_src        (out_alu_src),
    .out_mem_to_reg     (out_mem_to_reg),
    .out_reg_write      (out_reg_write),
    .out_mem_read       (out_mem_read),
    .out_mem_write      (out_mem_write),
    .out_branch         (out_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control order: reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
  // mem_write, branch, alu_op[2:0].
  localparam logic [9:0] C_NONE = 10'b0000000_000;
  localparam logic [9:0] C_RTYP = 10'b1001000_010;
  localparam logic [9:0] C_ADDI = 10'b0101000_000;
  localparam logic [9:0] C_LW   = 10'b0111100_000;
  localparam logic [9:0] C_BEQ  = 10'b0000001_001;

  localparam logic [31:0] I_ADDI9  = 32'h2009_0002; // addi $9,$0,2
  localparam logic [31:0] I_ADD11  = 32'h0120_5820; // add $11,$9,$0
  localparam logic [31:0] I_LW8    = 32'h8C08_0000; // lw $8,0($0)
  localparam logic [31:0] I_ADD10  = 32'h0108_5020; // add $10,$8,$8
  localparam logic [31:0] I_BEQ    = 32'h1000_FFFF; // beq $0,$0,-1
  localparam logic [31:0] I_ADDI12 = 32'h200C_0007; // addi $12,$0,7
  localparam logic [31:0] I_RD99   = 32'h0129_0020; // add $0,$9,$9

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        e_stall;
    logic [9:0]  e_ctrl;
    logic        chk_data;
    logic [4:0]  e_rs;
    logic [4:0]  e_rt;
    logic [31:0] e_imm;
    logic [31:0] e_rd1;
    logic [31:0] e_baddr;
    logic [31:0] e_pc4;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int n_cmp;
  int n_err;

  function automatic vec_t mkv(
    input logic [31:0] instr, input logic [31:0] pc4, input logic flush,
    input logic wb_we, input logic [4:0] wb_reg, input logic [31:0] wb_data,
    input logic e_stall, input logic [9:0] e_ctrl, input logic chk_data,
    input logic [4:0] e_rs, input logic [4:0] e_rt, input logic [31:0] e_imm,
    input logic [31:0] e_rd1, input logic [31:0] e_baddr, input logic [31:0] e_pc4);
    vec_t v;
    v.instr = instr;  v.pc4 = pc4;  v.flush = flush;
    v.wb_we = wb_we;  v.wb_reg = wb_reg;  v.wb_data = wb_data;
    v.e_stall = e_stall;  v.e_ctrl = e_ctrl;  v.chk_data = chk_data;
    v.e_rs = e_rs;  v.e_rt = e_rt;  v.e_imm = e_imm;
    v.e_rd1 = e_rd1;  v.e_baddr = e_baddr;  v.e_pc4 = e_pc4;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc4,
                       input logic flush, input logic wb_we,
                       input logic [4:0] wb_reg, input logic [31:0] wb_data);
    in_instruction   = instr;
    in_pc_plus_four  = pc4;
    in_flush         = flush;
    in_wb_reg_write  = wb_we;
    in_wb_write_reg  = wb_reg;
    in_wb_write_data = wb_data;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] obs_ctrl();
    return {out_reg_dst, out_alu_src, out_mem_to_reg, out_reg_write,
            out_mem_read, out_mem_write, out_branch, out_alu_op};
  endfunction

  function automatic logic [190:0] obs_all();
    return {out_pc_plus_four, out_branch_address, out_read_data_1,
            out_read_data_2, out_imm_ext, out_rs, out_rt, out_rd, out_funct,
            obs_ctrl()};
  endfunction

  task automatic check_all_zero(input string name);
    n_cmp++;
    if (obs_all() !== '0) begin
      n_err++;
      $display("FAIL %s: outputs %h expected all zero", name, obs_all());
    end
    check({name, "_stall"}, 0, 32'(out_stall), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);

    // Expected ID/EX contents after each edge; vector k's instruction reaches
    // ID/EX after edge k+1.
    vecs[0]  = mkv(I_ADDI9,  32'h04, 0, 0, 5'd0, 32'h0,
                   0, C_RTYP, 1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[1]  = mkv(I_ADD11,  32'h08, 0, 0, 5'd0, 32'h0,
                   0, C_ADDI, 1, 5'd0, 5'd9, 32'h2, 32'h0, 32'h0C, 32'h04);
    vecs[2]  = mkv(I_LW8,    32'h0C, 0, 1, 5'd9, 32'hDEAD_BEEF,
                   0, C_RTYP, 1, 5'd9, 5'd0, 32'h5820, 32'hDEAD_BEEF, 32'h0001_6088, 32'h08);
    vecs[3]  = mkv(I_ADD10,  32'h10, 0, 1, 5'd0, 32'h1234_5678,
                   1, C_LW,   1, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0C, 32'h0C);
    vecs[4]  = mkv(I_BEQ,    32'h10, 0, 0, 5'd0, 32'h0,
                   0, C_NONE, 0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[5]  = mkv(I_BEQ,    32'h10, 0, 0, 5'd0, 32'h0,
                   0, C_RTYP, 1, 5'd8, 5'd8, 32'h5020, 32'h0, 32'h0001_4090, 32'h10);
    vecs[6]  = mkv(I_ADDI12, 32'h14, 0, 0, 5'd0, 32'h0,
                   0, C_BEQ,  1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0C, 32'h10);
    vecs[7]  = mkv(I_LW8,    32'h18, 0, 0, 5'd0, 32'h0,
                   0, C_ADDI, 1, 5'd0, 5'd12, 32'h7, 32'h0, 32'h30, 32'h14);
    vecs[8]  = mkv(I_ADD10,  32'h1C, 0, 0, 5'd0, 32'h0,
                   1, C_LW,   1, 5'd0, 5'd8, 32'h0, 32'h0, 32'h18, 32'h18);
    vecs[9]  = mkv(I_ADDI9,  32'h20, 1, 0, 5'd0, 32'h0,
                   0, C_NONE, 0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[10] = mkv(I_ADDI9,  32'h24, 0, 0, 5'd0, 32'h0,
                   0, C_RTYP, 1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].instr, vecs[k].pc4, vecs[k].flush,
            vecs[k].wb_we, vecs[k].wb_reg, vecs[k].wb_data);
      step();
      check("stall", k, 32'(out_stall), 32'(vecs[k].e_stall));
      check("ctrl",  k, 32'(obs_ctrl()), 32'(vecs[k].e_ctrl));
      if (vecs[k].chk_data) begin
        check("rs",    k, 32'(out_rs), 32'(vecs[k].e_rs));
        check("rt",    k, 32'(out_rt), 32'(vecs[k].e_rt));
        check("imm",   k, out_imm_ext, vecs[k].e_imm);
        check("rd1",   k, out_read_data_1, vecs[k].e_rd1);
        check("baddr", k, out_branch_address, vecs[k].e_baddr);
        check("pc4",   k, out_pc_plus_four, vecs[k].e_pc4);
      end
    end

    // $9 keeps the value written back earlier.
    drive(I_RD99, 32'h28, 0, 0, 5'd0, 32'h0);
    step();
    drive(32'h0, 32'h2C, 0, 0, 5'd0, 32'h0);
    step();
    check("persist_rd1", 9, out_read_data_1, 32'hDEAD_BEEF);
    check("persist_rd2", 9, out_read_data_2, 32'hDEAD_BEEF);

    // Reset while a load-use stall is pending.
    drive(I_LW8, 32'h30, 0, 0, 5'd0, 32'h0);
    step();
    drive(I_ADD10, 32'h34, 0, 0, 5'd0, 32'h0);
    step();
    check("pre_rst_stall", 0, 32'(out_stall), 32'd1);
    rst = 1'b1;
    step();
    check_all_zero("mid_reset");
    rst = 1'b0;

    // Every register reads zero after reset (stream rs=rt=i through ID).
    for (int i = 0; i <= 32; i++) begin
      logic [31:0] w;
      logic [4:0]  r;
      r = 5'(i);
      w = {6'b000000, r, r, 5'd0, 5'd0, 6'h20};
      drive((i < 32) ? w : 32'h0, 32'h0, 0, 0, 5'd0, 32'h0);
      step();
      if (i > 0) begin
        check("clr_rs",  i - 1, 32'(out_rs), 32'(i - 1));
        check("clr_rd1", i - 1, out_read_data_1, 32'h0);
        check("clr_rd2", i - 1, out_read_data_2, 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the IF stage.
- Consumes instruction_out and pc_plus_four_out from IF through an internal IF/ID register.
- Holds the 32x32 register file, decodes control, sign-extends the immediate and computes the branch target.
- Drives a registered ID/EX bundle to EX, detects load-use hazards (stall to IF) and inserts bubbles on a branch flush.

Parameters:
- REG_COUNT, 32, number of architectural registers; index width is 5 bits.
- NOP_WORD, 32'h0000_0000, value loaded into the IF/ID instruction register on reset or flush.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_instruction  in  32  instruction from IF.
- in_pc_plus_four  in  32  PC+4 from IF.
- in_flush  in  1  taken branch resolved downstream (PCSrc); squash younger instructions.
- in_wb_reg_write  in  1  writeback enable.
- in_wb_write_reg  in  5  writeback register index.
- in_wb_write_data  in  32  writeback data.
- out_stall  out  1  load-use hazard; IF must hold PC and not present a new instruction.
- out_pc_plus_four  out  32  ID/EX copy of PC+4.
- out_branch_address  out  32  ID/EX: pc_plus_four + (sext(imm) << 2), modulo 2^32.
- out_read_data_1, out_read_data_2  out  32 each  ID/EX: rs and rt operand values.
- out_imm_ext  out  32  ID/EX: sign-extended imm[15:0].
- out_rs, out_rt, out_rd  out  5 each  ID/EX register indices.
- out_funct  out  6  ID/EX: instr[5:0].
- out_alu_op  out  3  ID/EX ALU op: 000 add, 001 sub, 010 use funct, 011 and, 100 or, 101 slt.
- out_reg_dst, out_alu_src, out_mem_to_reg, out_reg_write, out_mem_read, out_mem_write, out_branch  out  1 each  ID/EX control bits.

Behaviour:
- Reset (rst=1 at posedge):
  - IF/ID instruction <= NOP_WORD; IF/ID PC+4 <= 0.
  - All ID/EX outputs <= 0.
  - All 32 registers <= 0.
  - out_stall therefore reads 0 after reset.
  - Reset mid-operation discards any in-flight stall or flush.
- IF/ID register, updated each posedge by priority:
  - in_flush=1 -> load NOP_WORD and PC+4=0.
  - else out_stall=1 -> hold.
  - else load in_instruction / in_pc_plus_four.
- Decode acts on the IF/ID fields:
  - opcode = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0].
- Control table (reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op):
  - R-type 000000: 1,0,0,1,0,0,0,010.
  - addi 001000: 0,1,0,1,0,0,0,000.
  - andi 001100: 0,1,0,1,0,0,0,011.
  - ori 001101: 0,1,0,1,0,0,0,100.
  - slti 001010: 0,1,0,1,0,0,0,101.
  - lw 100011: 0,1,1,1,1,0,0,000.
  - sw 101011: x,1,x,0,0,1,0,000; x bits are driven 0.
  - beq 000100: x,0,x,0,0,0,1,001; x bits are driven 0.
  - Any other opcode: all control bits 0.
  - NOP_WORD decodes as R-type sll $0: reg_write=1 targeting $0, which is harmless.
  - andi/ori zero-extension is EX's job; out_imm_ext is always the sign extension.
- Register file:
  - Write at posedge when in_wb_reg_write=1 and in_wb_write_reg!=0.
  - Register $0 always reads 0.
  - Reads are combinational with write-through bypass: if wb_reg_write=1, wb_write_reg==index and index!=0, read returns in_wb_write_data in the same cycle.
- Hazard (combinational):
  - out_stall = out_mem_read & (out_rt!=0) & (out_rt==rs | (uses_rt & out_rt==rt)).
  - uses_rt is true for R-type, sw and beq.
- ID/EX register, updated each posedge:
  - in_flush=1 or out_stall=1 -> all control bits and out_alu_op <= 0 (bubble); data fields may update.
  - else load the decoded values.
  - Flush has priority over stall.
  - A stall lasts exactly one cycle, because the bubble clears out_mem_read.
- Latency: the instruction presented by IF at edge N appears on the ID/EX outputs after edge N+2; one IF/ID cycle plus one ID/EX cycle.
- Arithmetic: all additions are 32-bit and wrap silently.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LW, OP_SW, OP_BEQ);
  - ALU_OP_* 3-bit codes;
  - NOP_WORD.
- One natural sub-module: register_file (32x32, two read ports, one write port, bypass, $0 hardwired).
- Decode and hazard logic stay inline.

Test Plan:
- Reset, then present 32'h2009_0002 (addi $9,$0,2) with PC+4=4 -> two edges later out_reg_write=1, out_alu_src=1, out_rt=9, out_imm_ext=2, out_alu_op=000, out_pc_plus_four=4.
- WB writes 32'hDEAD_BEEF to $9 in the same cycle a decode reads rs=$9 -> ID/EX out_read_data_1=32'hDEAD_BEEF; a WB write to $0 leaves $0 reading 0.
- lw $8,0($0) followed by add $10,$8,$8:
  - out_stall=1 for exactly one cycle.
  - IF/ID holds the add; one bubble with all control bits 0 appears.
  - The add then emerges with out_rs=8.
- beq with imm=16'hFFFF at PC+4=32'h10 -> out_branch_address=32'h0C, out_branch=1, out_alu_op=001.
- in_flush=1 while an add sits in IF/ID and a stall condition is present -> next cycle IF/ID holds NOP_WORD and the ID/EX control bits are 0 (flush wins).
- Assert rst mid-stream with non-zero registers -> after one edge all outputs are 0, out_stall=0 and every register reads 0.
